fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Fetch-stage PC sequencer plus F/D pipeline register. Selects next PC each cycle
//  from sequential (+4), the static predictor redirect (PC + sign-extended branch
//  offset) or the execute-stage misprediction correction. Registers the fetched
//  instruction, PC and prediction bit into decode, and counts mispredictions.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset.
//  CNT_W     16             Width of saturating mispredict counter.
// PORTS
//  iClk             in   1      Clock, all state on rising edge.
//  iRstN            in   1      Async active-low reset.
//  iStallF          in   1      Hazard unit stall: hold PC and F/D register.
//  iInstrF          in   32     Instruction read from imem at oPCF.
//  iPredTakenF      in   1      Static predictor says taken (backward branch).
//  iPredOffsetF     in   32     Predictor's sign-extended B-type offset (bit0 = 0).
//  iMispredictE     in   1      Execute resolved branch opposite to prediction.
//  iCorrectPCE      in   32     PC to resume at when iMispredictE = 1.
//  oPCF             out  32     Current fetch PC (imem address).
//  oValidF          out  1      oPCF addresses a real fetch (0 during BOOT).
//  oFlushD          out  1      Combinational = iMispredictE; clears decode/exec.
//  oValidD          out  1      F/D register holds a live instruction.
//  oInstrD          out  32     Registered instruction.
//  oPCD             out  32     Registered PC of oInstrD.
//  oPCPlus4D        out  32     Registered PC+4 of oInstrD.
//  oPredTakenD      out  1      Registered prediction bit of oInstrD.
//  oMispredCnt      out  CNT_W  Saturating count of iMispredictE pulses.
// BEHAVIOUR
//  Reset (async, iRstN=0): oPCF=RESET_PC, FSM=BOOT, oValidF=0, oValidD=0,
//   oInstrD=32'h0000_0013 (NOP), oPCD=oPCPlus4D=0, oPredTakenD=0, oMispredCnt=0.
//  FSM: BOOT -> RUN after exactly one clock (imem latency cover); RUN is terminal
//   until reset. In BOOT: PC held at RESET_PC, predictions ignored, oValidF=0.
//  Next-PC priority (RUN): iMispredictE > iStallF > (iPredTakenF & oValidF) > PC+4.
//   - mispredict: PC <= iCorrectPCE even when iStallF=1.
//   - stall: PC holds.
//   - predicted: PC <= oPCF + iPredOffsetF.
//   - default: PC <= oPCF + 4.
//  All adds are 32-bit modulo 2^32 (0xFFFF_FFFC + 4 = 0); no alignment checks.
//  F/D register priority: iMispredictE or !oValidF -> bubble (oValidD=0,
//   oInstrD=NOP, oPredTakenD=0); else iStallF -> hold all; else capture iInstrF,
//   oPCF, oPCF+4, iPredTakenF, oValidD=1.
//  Latency: fetch at oPCF in cycle N appears on oInstrD/oPCD in cycle N+1.
//   Redirect (predicted or corrected) changes oPCF one edge after request.
//  oMispredCnt increments by 1 per cycle iMispredictE=1 (RUN only); saturates at
//   2^CNT_W-1, never wraps.
//  iMispredictE during BOOT: ignored for PC and counter; F/D still bubbles.
//  Reset asserted mid-operation: all state returns to reset values immediately.
// STRUCTURE
//  Shared pipeline package: NOP_INSTR (32'h13), OPCODE_BRANCH (7'd99), fetch FSM
//   enum {BOOT, RUN}, fd_reg_t struct {valid, instr, pc, pc_plus4, pred_taken}.
//  One sub-module is natural: sat_counter (CNT_W, iClk, iRstN, iInc, oCount).
//  PC mux/adders and F/D register stay in this module.
// TESTING
//  Reset release, RESET_PC=0x100: cycle0 oPCF=0x100 oValidF=0; cycle1 oValidF=1;
//   cycle2 oPCF=0x104, oPCD=0x100, oValidD=1.
//  PC=0x20, iPredTakenF=1, offset=0xFFFF_FFF8 -> next oPCF=0x18; oPredTakenD=1.
//  iStallF=1 for 3 cycles at PC=0x40 -> oPCF and oInstrD/oPCD unchanged; resumes 0x44.
//  iMispredictE=1, iCorrectPCE=0x200 with iStallF=1 and iPredTakenF=1 same cycle ->
//   oFlushD=1, oPCF=0x200 next, oValidD=0, oMispredCnt+1.
//  PC=0xFFFF_FFFC sequential -> next oPCF=0x0000_0000.
//  CNT_W=2, 5 mispredict pulses -> oMispredCnt=3 and holds.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: constants, the fetch FSM states and the
// F/D pipeline register layout.
package fetch_pc_unit_pkg;

   localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
   localparam logic [6:0]  OPCODE_BRANCH = 7'd99;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic        pred_taken;
   } fd_reg_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Bundle of fetch-stage signals between the PC unit (slave) and its
// environment: hazard unit, imem, predictor and execute stage (master).
interface fetch_pc_unit_if
   import fetch_pc_unit_pkg::*;
#(
   parameter int CNT_W = 16
);
   // No ready back-pressure exists: oValidF qualifies oPCF, oValidD qualifies the
   // F/D fields, and iStallF freezes both PC and F/D in the cycle it is high.
   logic              iStallF;
   logic [31:0]       iInstrF;
   logic              iPredTakenF;
   logic [31:0]       iPredOffsetF;
   logic              iMispredictE;
   logic [31:0]       iCorrectPCE;
   logic [31:0]       oPCF;
   logic              oValidF;
   logic              oFlushD;
   logic              oValidD;
   logic [31:0]       oInstrD;
   logic [31:0]       oPCD;
   logic [31:0]       oPCPlus4D;
   logic              oPredTakenD;
   logic [CNT_W-1:0]  oMispredCnt;
   fetch_state_e      oFsmState;

   modport slave (
      input  iStallF, iInstrF, iPredTakenF, iPredOffsetF, iMispredictE, iCorrectPCE,
      output oPCF, oValidF, oFlushD, oValidD, oInstrD, oPCD, oPCPlus4D,
             oPredTakenD, oMispredCnt, oFsmState
   );

   modport master (
      output iStallF, iInstrF, iPredTakenF, iPredOffsetF, iMispredictE, iCorrectPCE,
      input  oPCF, oValidF, oFlushD, oValidD, oInstrD, oPCD, oPCPlus4D,
             oPredTakenD, oMispredCnt, oFsmState
   );

endinterface

// File: rtl/fetch_pc_unit_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic             iInc,
   output logic [CNT_W-1:0] oCount
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_count <= '0;
      end else if (iInc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign oCount = r_count;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC sequencer (sequential / predicted / corrected) with the F/D
// pipeline register and a saturating mispredict counter.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic            iClk,
   input  logic            iRstN,
   fetch_pc_unit_if.slave  bus
);

   localparam fd_reg_t FD_RESET = '{1'b0, NOP_INSTR, 32'd0, 32'd0, 1'b0};

   fetch_state_e     r_state;
   fetch_state_e     w_state_next;
   logic [31:0]      r_pc;
   logic [31:0]      w_pc_next;
   logic [31:0]      w_pc_plus4;
   fd_reg_t          r_fd;
   fd_reg_t          w_fd_next;
   logic             w_run;
   logic             w_cnt_inc;
   logic [CNT_W-1:0] w_cnt;

   assign w_run      = (r_state == RUN);
   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_cnt_inc  = bus.iMispredictE && w_run;

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_state <= BOOT;
         r_pc    <= RESET_PC;
         r_fd    <= FD_RESET;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_fd    <= w_fd_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_fd_next    = r_fd;

      // BOOT only covers the first imem access latency, then RUN until reset
      case (r_state)
         BOOT:    w_state_next = RUN;
         RUN:     w_state_next = RUN;
         default: w_state_next = BOOT;
      endcase

      if (w_run) begin
         if (bus.iMispredictE) begin
            w_pc_next = bus.iCorrectPCE;
         end else if (bus.iStallF) begin
            w_pc_next = r_pc;
         end else if (bus.iPredTakenF) begin
            w_pc_next = r_pc + bus.iPredOffsetF;
         end else begin
            w_pc_next = w_pc_plus4;
         end
      end

      // A squashed or not-yet-valid fetch becomes a bubble; PC fields just hold
      if (bus.iMispredictE || !w_run) begin
         w_fd_next.valid      = 1'b0;
         w_fd_next.instr      = NOP_INSTR;
         w_fd_next.pred_taken = 1'b0;
      end else if (!bus.iStallF) begin
         w_fd_next = '{1'b1, bus.iInstrF, r_pc, w_pc_plus4, bus.iPredTakenF};
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_mispred_cnt (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iInc   (w_cnt_inc),
      .oCount (w_cnt)
   );

   assign bus.oPCF        = r_pc;
   assign bus.oValidF     = w_run;
   assign bus.oFlushD     = bus.iMispredictE;
   assign bus.oValidD     = r_fd.valid;
   assign bus.oInstrD     = r_fd.instr;
   assign bus.oPCD        = r_fd.pc;
   assign bus.oPCPlus4D   = r_fd.pc_plus4;
   assign bus.oPredTakenD = r_fd.pred_taken;
   assign bus.oMispredCnt = w_cnt;
   assign bus.oFsmState   = r_state;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: boot sequence, prediction, stall,
// mispredict priority, PC wrap, mid-run reset and counter saturation.
module tb_fetch_pc_unit;
   import fetch_pc_unit_pkg::*;

   localparam int          CNT_W    = 2;
   localparam logic [31:0] RST_PC   = 32'h0000_0100;
   localparam logic [31:0] IMEM_KEY = 32'hA5A5_0000;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   logic [CNT_W-1:0] exp_cnt;

   fetch_pc_unit_if #(.CNT_W(CNT_W)) bus ();

   fetch_pc_unit #(
      .RESET_PC (RST_PC),
      .CNT_W    (CNT_W)
   ) dut (
      .iClk  (clk),
      .iRstN (rst_n),
      .bus   (bus)
   );

   // imem model: instruction word is the address scrambled with a key
   assign bus.iInstrF = bus.oPCF ^ IMEM_KEY;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.iStallF      = 1'b0;
      bus.iPredTakenF  = 1'b0;
      bus.iPredOffsetF = 32'd0;
      bus.iMispredictE = 1'b0;
      bus.iCorrectPCE  = 32'd0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      #12;
      n_cmp++; if (bus.oPCF !== RST_PC) begin n_err++; $display("FAIL rst_pc got %h want %h", bus.oPCF, RST_PC); end
      n_cmp++; if (bus.oValidF !== 1'b0) begin n_err++; $display("FAIL rst_validf got %b want 0", bus.oValidF); end
      n_cmp++; if (bus.oValidD !== 1'b0) begin n_err++; $display("FAIL rst_validd got %b want 0", bus.oValidD); end
      n_cmp++; if (bus.oInstrD !== 32'h0000_0013) begin n_err++; $display("FAIL rst_instrd got %h want 00000013", bus.oInstrD); end
      n_cmp++; if ({bus.oPCD, bus.oPCPlus4D} !== 64'd0) begin n_err++; $display("FAIL rst_pcd got %h/%h want 0/0", bus.oPCD, bus.oPCPlus4D); end
      n_cmp++; if (bus.oPredTakenD !== 1'b0) begin n_err++; $display("FAIL rst_predd got %b want 0", bus.oPredTakenD); end
      n_cmp++; if (bus.oMispredCnt !== 2'd0) begin n_err++; $display("FAIL rst_cnt got %0d want 0", bus.oMispredCnt); end
      n_cmp++; if (bus.oFsmState !== BOOT) begin n_err++; $display("FAIL rst_state got %0d want BOOT", bus.oFsmState); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_cmp++; if ({bus.oPCF, bus.oValidF} !== {RST_PC, 1'b0}) begin n_err++; $display("FAIL boot_c0 got %h/%b want %h/0", bus.oPCF, bus.oValidF, RST_PC); end
      tick();
      n_cmp++; if ({bus.oPCF, bus.oValidF, bus.oValidD} !== {RST_PC, 1'b1, 1'b0}) begin n_err++; $display("FAIL boot_c1 got %h/%b/%b want %h/1/0", bus.oPCF, bus.oValidF, bus.oValidD, RST_PC); end
      n_cmp++; if (bus.oFsmState !== RUN) begin n_err++; $display("FAIL boot_state got %0d want RUN", bus.oFsmState); end
      tick();
      n_cmp++; if (bus.oPCF !== 32'h104) begin n_err++; $display("FAIL boot_c2_pc got %h want 00000104", bus.oPCF); end
      n_cmp++; if ({bus.oValidD, bus.oPCD, bus.oPCPlus4D} !== {1'b1, 32'h100, 32'h104}) begin n_err++; $display("FAIL boot_c2_fd got %b/%h/%h want 1/00000100/00000104", bus.oValidD, bus.oPCD, bus.oPCPlus4D); end
      n_cmp++; if (bus.oInstrD !== (32'h100 ^ IMEM_KEY)) begin n_err++; $display("FAIL boot_c2_instr got %h want %h", bus.oInstrD, 32'h100 ^ IMEM_KEY); end
   endtask

   task automatic test_predict();
      bus.iMispredictE = 1'b1;
      bus.iCorrectPCE  = 32'h20;
      #1;
      n_cmp++; if (bus.oFlushD !== 1'b1) begin n_err++; $display("FAIL pred_flush got %b want 1", bus.oFlushD); end
      tick();
      exp_cnt = 2'd1;
      clear_inputs();
      n_cmp++; if ({bus.oPCF, bus.oValidD} !== {32'h20, 1'b0}) begin n_err++; $display("FAIL pred_setup got %h/%b want 00000020/0", bus.oPCF, bus.oValidD); end
      n_cmp++; if (bus.oMispredCnt !== exp_cnt) begin n_err++; $display("FAIL pred_cnt got %0d want %0d", bus.oMispredCnt, exp_cnt); end
      bus.iPredTakenF  = 1'b1;
      bus.iPredOffsetF = 32'hFFFF_FFF8;
      tick();
      clear_inputs();
      n_cmp++; if (bus.oPCF !== 32'h18) begin n_err++; $display("FAIL pred_pc got %h want 00000018", bus.oPCF); end
      n_cmp++; if ({bus.oValidD, bus.oPredTakenD, bus.oPCD} !== {1'b1, 1'b1, 32'h20}) begin n_err++; $display("FAIL pred_fd got %b/%b/%h want 1/1/00000020", bus.oValidD, bus.oPredTakenD, bus.oPCD); end
      n_cmp++; if (bus.oInstrD !== (32'h20 ^ IMEM_KEY)) begin n_err++; $display("FAIL pred_instr got %h want %h", bus.oInstrD, 32'h20 ^ IMEM_KEY); end
   endtask

   task automatic test_stall();
      bus.iMispredictE = 1'b1;
      bus.iCorrectPCE  = 32'h3C;
      tick();
      exp_cnt = 2'd2;
      clear_inputs();
      tick();
      n_cmp++; if ({bus.oPCF, bus.oPCD} !== {32'h40, 32'h3C}) begin n_err++; $display("FAIL stall_setup got %h/%h want 00000040/0000003c", bus.oPCF, bus.oPCD); end
      bus.iStallF = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if ({bus.oPCF, bus.oPCD, bus.oValidD} !== {32'h40, 32'h3C, 1'b1}) begin n_err++; $display("FAIL stall_hold%0d got %h/%h/%b want 00000040/0000003c/1", i, bus.oPCF, bus.oPCD, bus.oValidD); end
         n_cmp++; if (bus.oInstrD !== (32'h3C ^ IMEM_KEY)) begin n_err++; $display("FAIL stall_instr%0d got %h want %h", i, bus.oInstrD, 32'h3C ^ IMEM_KEY); end
      end
      bus.iStallF = 1'b0;
      tick();
      n_cmp++; if ({bus.oPCF, bus.oPCD} !== {32'h44, 32'h40}) begin n_err++; $display("FAIL stall_resume got %h/%h want 00000044/00000040", bus.oPCF, bus.oPCD); end
      n_cmp++; if (bus.oMispredCnt !== exp_cnt) begin n_err++; $display("FAIL stall_cnt got %0d want %0d", bus.oMispredCnt, exp_cnt); end
   endtask

   task automatic test_mispredict_priority();
      bus.iStallF      = 1'b1;
      bus.iPredTakenF  = 1'b1;
      bus.iPredOffsetF = 32'h8;
      bus.iMispredictE = 1'b1;
      bus.iCorrectPCE  = 32'h200;
      #1;
      n_cmp++; if (bus.oFlushD !== 1'b1) begin n_err++; $display("FAIL prio_flush got %b want 1", bus.oFlushD); end
      tick();
      exp_cnt = 2'd3;
      clear_inputs();
      n_cmp++; if (bus.oPCF !== 32'h200) begin n_err++; $display("FAIL prio_pc got %h want 00000200", bus.oPCF); end
      n_cmp++; if ({bus.oValidD, bus.oPredTakenD, bus.oInstrD} !== {1'b0, 1'b0, NOP_INSTR}) begin n_err++; $display("FAIL prio_bubble got %b/%b/%h want 0/0/00000013", bus.oValidD, bus.oPredTakenD, bus.oInstrD); end
      n_cmp++; if (bus.oMispredCnt !== exp_cnt) begin n_err++; $display("FAIL prio_cnt got %0d want %0d", bus.oMispredCnt, exp_cnt); end
      n_cmp++; if (bus.oFlushD !== 1'b0) begin n_err++; $display("FAIL prio_noflush got %b want 0", bus.oFlushD); end
   endtask

   task automatic test_wrap();
      bus.iMispredictE = 1'b1;
      bus.iCorrectPCE  = 32'hFFFF_FFFC;
      tick();
      clear_inputs();
      n_cmp++; if (bus.oMispredCnt !== 2'd3) begin n_err++; $display("FAIL wrap_cnt_sat got %0d want 3", bus.oMispredCnt); end
      tick();
      n_cmp++; if (bus.oPCF !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h want 00000000", bus.oPCF); end
      n_cmp++; if ({bus.oPCD, bus.oPCPlus4D} !== {32'hFFFF_FFFC, 32'h0}) begin n_err++; $display("FAIL wrap_fd got %h/%h want fffffffc/00000000", bus.oPCD, bus.oPCPlus4D); end
   endtask

   task automatic test_reset_mid();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({bus.oPCF, bus.oValidF, bus.oValidD} !== {RST_PC, 1'b0, 1'b0}) begin n_err++; $display("FAIL midrst_pc got %h/%b/%b want %h/0/0", bus.oPCF, bus.oValidF, bus.oValidD, RST_PC); end
      n_cmp++; if ({bus.oMispredCnt, bus.oInstrD} !== {2'd0, NOP_INSTR}) begin n_err++; $display("FAIL midrst_state got %0d/%h want 0/00000013", bus.oMispredCnt, bus.oInstrD); end
      tick();
      rst_n = 1'b1;
      bus.iMispredictE = 1'b1;
      bus.iCorrectPCE  = 32'h300;
      #1;
      n_cmp++; if (bus.oFlushD !== 1'b1) begin n_err++; $display("FAIL bootmis_flush got %b want 1", bus.oFlushD); end
      tick();
      clear_inputs();
      n_cmp++; if ({bus.oPCF, bus.oValidD} !== {RST_PC, 1'b0}) begin n_err++; $display("FAIL bootmis_pc got %h/%b want %h/0", bus.oPCF, bus.oValidD, RST_PC); end
      n_cmp++; if (bus.oMispredCnt !== 2'd0) begin n_err++; $display("FAIL bootmis_cnt got %0d want 0", bus.oMispredCnt); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_pc;
      exp_cnt = 2'd0;
      for (int i = 0; i < 5; i++) begin
         exp_pc           = 32'h500 + 32'(i * 4);
         bus.iMispredictE = 1'b1;
         bus.iCorrectPCE  = exp_pc;
         tick();
         if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
         n_cmp++; if (bus.oMispredCnt !== exp_cnt) begin n_err++; $display("FAIL b2b_cnt%0d got %0d want %0d", i, bus.oMispredCnt, exp_cnt); end
         n_cmp++; if ({bus.oPCF, bus.oValidD} !== {exp_pc, 1'b0}) begin n_err++; $display("FAIL b2b_pc%0d got %h/%b want %h/0", i, bus.oPCF, bus.oValidD, exp_pc); end
      end
      clear_inputs();
      tick();
      n_cmp++; if (bus.oMispredCnt !== 2'd3) begin n_err++; $display("FAIL b2b_hold got %0d want 3", bus.oMispredCnt); end
      n_cmp++; if ({bus.oPCF, bus.oPCD, bus.oValidD} !== {32'h514, 32'h510, 1'b1}) begin n_err++; $display("FAIL b2b_resume got %h/%h/%b want 00000514/00000510/1", bus.oPCF, bus.oPCD, bus.oValidD); end
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      exp_cnt = '0;
      test_reset();
      test_predict();
      test_stall();
      test_mispredict_priority();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
